// File: rtl/estacao_reserva_add.sv
// Single-entry reservation station for the ADD/SUB unit: captures one dispatched op,
// snoops the CDB for pending operands, runs a LATENCY-cycle add/sub and broadcasts the result.
module estacao_reserva_add #(
   parameter logic [2:0]  STATION_ID = 3'd1,
   parameter int          LATENCY    = 2,
   parameter logic [15:0] SEM_VALOR  = 16'hFFF0
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Enable_VQ,
   input  logic [2:0]  Ufop,
   input  logic [15:0] Vj,
   input  logic [15:0] Vk,
   input  logic [2:0]  Qj,
   input  logic [2:0]  Qk,
   input  logic [3:0]  R_target,
   input  logic        CDB_valid,
   input  logic [2:0]  CDB_tag,
   input  logic [15:0] CDB_data,
   input  logic        CDB_grant,
   output logic        Busy,
   output logic        CDB_req,
   output logic [2:0]  CDB_out_tag,
   output logic [15:0] CDB_out_data,
   output logic [3:0]  CDB_out_Rtgt,
   output logic        Drop
);
   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] WAIT_OPS = 2'd1;
   localparam logic [1:0] EXEC     = 2'd2;
   localparam logic [1:0] WB       = 2'd3;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   logic [1:0]  r_state;
   logic [15:0] r_vj, r_vk, r_out_data;
   logic [2:0]  r_qj, r_qk, r_op, r_out_tag;
   logic [3:0]  r_rt, r_cnt, r_out_rt;
   logic        r_req, r_drop;

   logic        w_hit_j_disp, w_hit_k_disp, w_hit_j_wait, w_hit_k_wait;
   logic [15:0] w_vj_disp, w_vk_disp, w_result;
   logic [2:0]  w_qj_disp, w_qk_disp;

   // A nonzero Q matching the CDB tag resolves the operand; tag 0 can never match.
   assign w_hit_j_disp = (Qj != 3'd0) && CDB_valid && (CDB_tag == Qj);
   assign w_hit_k_disp = (Qk != 3'd0) && CDB_valid && (CDB_tag == Qk);
   assign w_hit_j_wait = (r_qj != 3'd0) && CDB_valid && (CDB_tag == r_qj);
   assign w_hit_k_wait = (r_qk != 3'd0) && CDB_valid && (CDB_tag == r_qk);

   assign w_vj_disp = (Qj == 3'd0) ? Vj : (w_hit_j_disp ? CDB_data : SEM_VALOR);
   assign w_vk_disp = (Qk == 3'd0) ? Vk : (w_hit_k_disp ? CDB_data : SEM_VALOR);
   assign w_qj_disp = w_hit_j_disp ? 3'd0 : Qj;
   assign w_qk_disp = w_hit_k_disp ? 3'd0 : Qk;

   always_comb begin
      w_result = 16'h0000;
      case (r_op)
         3'b001:  w_result = r_vj + r_vk;
         3'b010:  w_result = r_vj - r_vk;
         default: w_result = 16'h0000;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state    <= IDLE;
         r_vj       <= SEM_VALOR;
         r_vk       <= SEM_VALOR;
         r_qj       <= 3'd0;
         r_qk       <= 3'd0;
         r_op       <= 3'd0;
         r_rt       <= 4'd0;
         r_cnt      <= 4'd0;
         r_req      <= 1'b0;
         r_drop     <= 1'b0;
         r_out_tag  <= 3'd0;
         r_out_data <= 16'h0000;
         r_out_rt   <= 4'd0;
      end else begin
         r_drop <= Enable_VQ && (r_state != IDLE);
         case (r_state)
            IDLE: if (Enable_VQ) begin
               r_op    <= Ufop;
               r_rt    <= R_target;
               r_vj    <= w_vj_disp;
               r_vk    <= w_vk_disp;
               r_qj    <= w_qj_disp;
               r_qk    <= w_qk_disp;
               r_cnt   <= CNT_LOAD;
               r_state <= ((w_qj_disp == 3'd0) && (w_qk_disp == 3'd0)) ? EXEC : WAIT_OPS;
            end
            WAIT_OPS: begin
               if (w_hit_j_wait) begin
                  r_vj <= CDB_data;
                  r_qj <= 3'd0;
               end
               if (w_hit_k_wait) begin
                  r_vk <= CDB_data;
                  r_qk <= 3'd0;
               end
               if (((r_qj == 3'd0) || w_hit_j_wait) && ((r_qk == 3'd0) || w_hit_k_wait)) begin
                  r_cnt   <= CNT_LOAD;
                  r_state <= EXEC;
               end
            end
            EXEC: if (r_cnt == 4'd0) begin
               r_out_data <= w_result;
               r_out_rt   <= r_rt;
               r_out_tag  <= STATION_ID;
               r_req      <= 1'b1;
               r_state    <= WB;
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
            WB: if (CDB_grant) begin
               r_req     <= 1'b0;
               r_out_tag <= 3'd0;
               r_state   <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign Busy         = (r_state != IDLE);
   assign CDB_req      = r_req;
   assign CDB_out_tag  = r_out_tag;
   assign CDB_out_data = r_out_data;
   assign CDB_out_Rtgt = r_out_rt;
   assign Drop         = r_drop;
endmodule

// File: tb/tb_estacao_reserva_add.sv
// Self-checking bench for estacao_reserva_add: directed scenarios plus randomized
// dispatch/CDB traffic against a plain arithmetic reference model.
module tb_estacao_reserva_add;
   localparam int          LAT = 2;
   localparam logic [2:0]  SID = 3'd1;

   logic        Clock = 1'b0, Reset = 1'b1, Enable_VQ = 1'b0;
   logic [2:0]  Ufop = 3'd0, Qj = 3'd0, Qk = 3'd0, CDB_tag = 3'd0;
   logic [15:0] Vj = 16'd0, Vk = 16'd0, CDB_data = 16'd0;
   logic [3:0]  R_target = 4'd0;
   logic        CDB_valid = 1'b0, CDB_grant = 1'b0;
   logic        Busy, CDB_req, Drop;
   logic [2:0]  CDB_out_tag;
   logic [15:0] CDB_out_data;
   logic [3:0]  CDB_out_Rtgt;
   int n_chk = 0, n_pass = 0;

   estacao_reserva_add #(.STATION_ID(SID), .LATENCY(LAT), .SEM_VALOR(16'hFFF0)) dut (
      .Clock(Clock), .Reset(Reset), .Enable_VQ(Enable_VQ), .Ufop(Ufop), .Vj(Vj), .Vk(Vk),
      .Qj(Qj), .Qk(Qk), .R_target(R_target), .CDB_valid(CDB_valid), .CDB_tag(CDB_tag),
      .CDB_data(CDB_data), .CDB_grant(CDB_grant), .Busy(Busy), .CDB_req(CDB_req),
      .CDB_out_tag(CDB_out_tag), .CDB_out_data(CDB_out_data), .CDB_out_Rtgt(CDB_out_Rtgt),
      .Drop(Drop));

   always #5 Clock = ~Clock;

   function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
      if (op == 3'b001) return 16'((32'(a) + 32'(b)) % 65536);
      if (op == 3'b010) return 16'((32'(a) + 65536 - 32'(b)) % 65536);
      return 16'h0000;
   endfunction

   task automatic test_reset();
      @(negedge Clock); Reset = 1'b1;
      @(negedge Clock); @(negedge Clock);
      n_chk++; if ({Busy, CDB_req, CDB_out_tag, CDB_out_data, CDB_out_Rtgt, Drop} !== 26'd0)
         $display("FAIL reset_outputs got=%h exp=0", {Busy, CDB_req, CDB_out_tag, CDB_out_data, CDB_out_Rtgt, Drop}); else n_pass++;
      Reset = 1'b0;
   endtask

   // Dispatch with operands ready, grant held high; checks latency, result, tag, release.
   task automatic run_op(input string nm, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic [3:0] rt);
      int t;
      @(negedge Clock);
      Enable_VQ = 1'b1; Ufop = op; Vj = a; Vk = b; Qj = 3'd0; Qk = 3'd0; R_target = rt; CDB_grant = 1'b1;
      t = 0;
      do begin @(negedge Clock); Enable_VQ = 1'b0; t++; end while (!CDB_req && t < 20);
      n_chk++; if (t !== LAT + 1) $display("FAIL %s_latency got=%0d exp=%0d", nm, t, LAT + 1); else n_pass++;
      n_chk++; if (CDB_out_data !== alu(op, a, b)) $display("FAIL %s_data got=%h exp=%h", nm, CDB_out_data, alu(op, a, b)); else n_pass++;
      n_chk++; if (CDB_out_tag !== SID || CDB_out_Rtgt !== rt) $display("FAIL %s_tag_rtgt got=%0d/%0d exp=%0d/%0d", nm, CDB_out_tag, CDB_out_Rtgt, SID, rt); else n_pass++;
      @(negedge Clock);
      n_chk++; if (Busy !== 1'b0 || CDB_req !== 1'b0 || CDB_out_tag !== 3'd0)
         $display("FAIL %s_release got busy=%b req=%b tag=%0d exp=0/0/0", nm, Busy, CDB_req, CDB_out_tag); else n_pass++;
      CDB_grant = 1'b0;
   endtask

   task automatic test_basic();
      @(negedge Clock);
      Enable_VQ = 1'b1; Ufop = 3'b001; Vj = 16'd5; Vk = 16'd7; Qj = 3'd0; Qk = 3'd0; R_target = 4'd3; CDB_grant = 1'b1;
      @(negedge Clock); Enable_VQ = 1'b0;
      n_chk++; if (Busy !== 1'b1 || CDB_req !== 1'b0) $display("FAIL t1_cycle1 got busy=%b req=%b exp=1/0", Busy, CDB_req); else n_pass++;
      @(negedge Clock);
      n_chk++; if (CDB_req !== 1'b0) $display("FAIL t1_cycle2_req got=%b exp=0", CDB_req); else n_pass++;
      @(negedge Clock);
      n_chk++; if (CDB_req !== 1'b1 || CDB_out_data !== 16'd12 || CDB_out_tag !== 3'd1 || CDB_out_Rtgt !== 4'd3)
         $display("FAIL t1_cycle3 got req=%b data=%0d tag=%0d rt=%0d exp=1/12/1/3", CDB_req, CDB_out_data, CDB_out_tag, CDB_out_Rtgt); else n_pass++;
      @(negedge Clock);
      n_chk++; if (Busy !== 1'b0 || CDB_req !== 1'b0) $display("FAIL t1_cycle4 got busy=%b req=%b exp=0/0", Busy, CDB_req); else n_pass++;
      CDB_grant = 1'b0;
   endtask

   task automatic test_arith();
      run_op("sub_wrap", 3'b010, 16'd0, 16'd1, 4'd1);
      run_op("add_wrap", 3'b001, 16'hFFFF, 16'h0002, 4'd2);
      run_op("bad_op", 3'b011, 16'h1234, 16'h4321, 4'd15);
   endtask

   task automatic test_snoop();
      int t;
      @(negedge Clock);
      Enable_VQ = 1'b1; Ufop = 3'b001; Vj = 16'hAAAA; Vk = 16'd3; Qj = 3'd2; Qk = 3'd0; R_target = 4'd6;
      for (int c = 1; c <= 4; c++) begin
         @(negedge Clock); Enable_VQ = 1'b0;
         CDB_valid = 1'b1;
         CDB_tag = (c == 4) ? 3'd2 : 3'd3;
         CDB_data = (c == 4) ? 16'd10 : 16'd99;
      end
      n_chk++; if (Busy !== 1'b1 || CDB_req !== 1'b0) $display("FAIL t3_waiting got busy=%b req=%b exp=1/0", Busy, CDB_req); else n_pass++;
      t = 0;
      do begin @(negedge Clock); CDB_valid = 1'b0; t++; end while (!CDB_req && t < 20);
      n_chk++; if (t !== LAT + 1) $display("FAIL t3_latency got=%0d exp=%0d", t, LAT + 1); else n_pass++;
      n_chk++; if (CDB_out_data !== 16'd13) $display("FAIL t3_data got=%0d exp=13", CDB_out_data); else n_pass++;
      CDB_grant = 1'b1; @(negedge Clock); CDB_grant = 1'b0;
   endtask

   task automatic test_bypass();
      int t;
      @(negedge Clock);
      Enable_VQ = 1'b1; Ufop = 3'b001; Vj = 16'h5555; Vk = 16'd4; Qj = 3'd2; Qk = 3'd0; R_target = 4'd8;
      CDB_valid = 1'b1; CDB_tag = 3'd2; CDB_data = 16'd9;
      t = 0;
      do begin @(negedge Clock); Enable_VQ = 1'b0; CDB_valid = 1'b0; t++; end while (!CDB_req && t < 20);
      n_chk++; if (t !== LAT + 1) $display("FAIL t4_latency got=%0d exp=%0d", t, LAT + 1); else n_pass++;
      n_chk++; if (CDB_out_data !== 16'd13) $display("FAIL t4_data got=%0d exp=13", CDB_out_data); else n_pass++;
      CDB_grant = 1'b1; @(negedge Clock); CDB_grant = 1'b0;
   endtask

   task automatic test_hold_drop();
      int t;
      @(negedge Clock);
      Enable_VQ = 1'b1; Ufop = 3'b010; Vj = 16'd100; Vk = 16'd30; Qj = 3'd0; Qk = 3'd0; R_target = 4'd9; CDB_grant = 1'b0;
      t = 0;
      do begin @(negedge Clock); Enable_VQ = 1'b0; t++; end while (!CDB_req && t < 20);
      n_chk++; if (CDB_req !== 1'b1) $display("FAIL t5_req_timeout got=%b exp=1", CDB_req); else n_pass++;
      for (int k = 0; k < 5; k++) begin
         if (k == 1) begin
            Enable_VQ = 1'b1; Ufop = 3'b001; Vj = 16'd1; Vk = 16'd1; Qj = 3'd3; R_target = 4'd2;
         end
         @(negedge Clock); Enable_VQ = 1'b0;
         n_chk++; if (CDB_req !== 1'b1 || Busy !== 1'b1 || CDB_out_data !== 16'd70 || CDB_out_tag !== SID || CDB_out_Rtgt !== 4'd9)
            $display("FAIL t5_hold%0d got req=%b busy=%b data=%0d tag=%0d rt=%0d exp=1/1/70/1/9", k, CDB_req, Busy, CDB_out_data, CDB_out_tag, CDB_out_Rtgt); else n_pass++;
         n_chk++; if (Drop !== (k == 1)) $display("FAIL t5_drop%0d got=%b exp=%b", k, Drop, k == 1); else n_pass++;
      end
      CDB_grant = 1'b1; Enable_VQ = 1'b1; Qj = 3'd0;
      @(negedge Clock); CDB_grant = 1'b0; Enable_VQ = 1'b0;
      n_chk++; if (Busy !== 1'b0 || CDB_req !== 1'b0 || CDB_out_tag !== 3'd0 || Drop !== 1'b1)
         $display("FAIL t5_grant got busy=%b req=%b tag=%0d drop=%b exp=0/0/0/1", Busy, CDB_req, CDB_out_tag, Drop); else n_pass++;
      @(negedge Clock);
      n_chk++; if (Busy !== 1'b0 || Drop !== 1'b0) $display("FAIL t5_after got busy=%b drop=%b exp=0/0", Busy, Drop); else n_pass++;
   endtask

   task automatic test_reset_abort();
      int t;
      @(negedge Clock);
      Enable_VQ = 1'b1; Ufop = 3'b001; Vj = 16'd1; Vk = 16'd2; Qj = 3'd0; Qk = 3'd0; R_target = 4'd4; CDB_grant = 1'b0;
      @(negedge Clock); Enable_VQ = 1'b0; Reset = 1'b1;
      @(negedge Clock); Reset = 1'b0;
      n_chk++; if ({Busy, CDB_req, CDB_out_tag, CDB_out_data, CDB_out_Rtgt, Drop} !== 26'd0)
         $display("FAIL t6_exec_reset got=%h exp=0", {Busy, CDB_req, CDB_out_tag, CDB_out_data, CDB_out_Rtgt, Drop}); else n_pass++;
      for (int c = 0; c < 4; c++) begin
         @(negedge Clock);
         n_chk++; if (CDB_req !== 1'b0 || Busy !== 1'b0) $display("FAIL t6_exec_quiet%0d got req=%b busy=%b exp=0/0", c, CDB_req, Busy); else n_pass++;
      end
      Enable_VQ = 1'b1; Vj = 16'd40; Vk = 16'd2; R_target = 4'd5;
      t = 0;
      do begin @(negedge Clock); Enable_VQ = 1'b0; t++; end while (!CDB_req && t < 20);
      n_chk++; if (CDB_req !== 1'b1 || CDB_out_data !== 16'd42) $display("FAIL t6_wb_setup got req=%b data=%0d exp=1/42", CDB_req, CDB_out_data); else n_pass++;
      Reset = 1'b1;
      @(negedge Clock); Reset = 1'b0;
      n_chk++; if ({Busy, CDB_req, CDB_out_tag, CDB_out_data, CDB_out_Rtgt, Drop} !== 26'd0)
         $display("FAIL t6_wb_reset got=%h exp=0", {Busy, CDB_req, CDB_out_tag, CDB_out_data, CDB_out_Rtgt, Drop}); else n_pass++;
      run_op("t6_redispatch", 3'b010, 16'd50, 16'd8, 4'd7);
   endtask

   // Random dispatches with random pending tags and CDB traffic.
   task automatic test_random();
      logic [2:0]  op, qj, qk;
      logic [15:0] ej, ek;
      logic [3:0]  rt;
      int t, done_t, d;
      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 3))
            0: op = 3'b001; 1: op = 3'b010; 2: op = 3'($urandom); default: op = 3'b001;
         endcase
         qj = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         qk = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         ej = 16'($urandom); ek = 16'($urandom); rt = 4'($urandom);
         @(negedge Clock);
         Enable_VQ = 1'b1; Ufop = op; Vj = ej; Vk = ek; Qj = qj; Qk = qk; R_target = rt; CDB_grant = 1'b0;
         CDB_valid = 1'($urandom); CDB_tag = 3'($urandom); CDB_data = 16'($urandom);
         t = 0; done_t = -1;
         while (1) begin
            if (CDB_valid && CDB_tag != 3'd0 && CDB_tag == qj) begin ej = CDB_data; qj = 3'd0; end
            if (CDB_valid && CDB_tag != 3'd0 && CDB_tag == qk) begin ek = CDB_data; qk = 3'd0; end
            if (done_t < 0 && qj == 3'd0 && qk == 3'd0) done_t = t;
            @(negedge Clock); t++; Enable_VQ = 1'b0;
            if (CDB_req || t >= 40) break;
            CDB_data = 16'($urandom);
            if (done_t < 0 && t >= 6) begin
               CDB_valid = 1'b1; CDB_tag = (qj != 3'd0) ? qj : qk;
            end else begin
               CDB_valid = 1'($urandom); CDB_tag = 3'($urandom);
            end
         end
         CDB_valid = 1'b0;
         n_chk++; if (t !== done_t + LAT + 1) $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, t, done_t + LAT + 1); else n_pass++;
         n_chk++; if (CDB_out_data !== alu(op, ej, ek) || CDB_out_tag !== SID || CDB_out_Rtgt !== rt)
            $display("FAIL rnd%0d_result got=%h/%0d/%0d exp=%h/%0d/%0d", it, CDB_out_data, CDB_out_tag, CDB_out_Rtgt, alu(op, ej, ek), SID, rt); else n_pass++;
         d = $urandom_range(0, 3);
         for (int c = 0; c < d; c++) @(negedge Clock);
         CDB_grant = 1'b1;
         @(negedge Clock); CDB_grant = 1'b0;
         n_chk++; if (Busy !== 1'b0 || CDB_req !== 1'b0) $display("FAIL rnd%0d_release got busy=%b req=%b exp=0/0", it, Busy, CDB_req); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_arith();
      test_snoop();
      test_bypass();
      test_hold_drop();
      test_reset_abort();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
